// File: rtl/mem_arbiter_n.sv
// Round-robin arbiter of NUM_PORTS request channels onto a byte-wide RAM/IO bus.
// Serialises multi-byte transfers, stalls UART writes, and supports read abort.
module mem_arbiter_n #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MAX_BYTES = 4
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              rdy_in,
    input  logic [NUM_PORTS-1:0]              req_valid,
    input  logic [NUM_PORTS-1:0]              req_we,
    input  logic [NUM_PORTS*ADDR_W-1:0]       req_addr,
    input  logic [NUM_PORTS*3-1:0]            req_len,
    input  logic [NUM_PORTS*8*MAX_BYTES-1:0]  req_wdata,
    input  logic [NUM_PORTS-1:0]              req_abort,
    output logic [NUM_PORTS-1:0]              resp_done,
    output logic [8*MAX_BYTES-1:0]            resp_rdata,
    input  logic [7:0]                        mem_din,
    output logic [7:0]                        mem_dout,
    output logic [ADDR_W-1:0]                 mem_a,
    output logic                              mem_wr,
    input  logic                              io_buffer_full
);

    localparam int unsigned DATA_W = 8 * MAX_BYTES;
    localparam int unsigned LEN_W  = 3;
    localparam int unsigned GNT_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t             state;
    logic [GNT_W-1:0]   last_grant;
    logic [LEN_W-1:0]   xfer_len;
    logic [LEN_W-1:0]   byte_idx;
    logic [DATA_W-1:0]  wbuf;

    logic               gnt_found_c;
    logic [GNT_W-1:0]   gnt_port_c;
    logic [GNT_W-1:0]   cand_c;
    logic               io_stall_c;
    logic [NUM_PORTS-1:0] done_oh_c;
    logic [LEN_W-1:0]   cap_idx_c;

    // First valid port strictly after last_grant, wrapping around.
    always_comb begin
        gnt_found_c = 1'b0;
        gnt_port_c  = last_grant;
        cand_c      = last_grant;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            cand_c = GNT_W'((32'(last_grant) + i) % NUM_PORTS);
            if (!gnt_found_c && req_valid[cand_c]) begin
                gnt_found_c = 1'b1;
                gnt_port_c  = cand_c;
            end
        end
    end

    assign io_stall_c = (mem_a[17:16] == 2'b11) && io_buffer_full;
    assign done_oh_c  = NUM_PORTS'(1) << last_grant;
    assign cap_idx_c  = byte_idx - LEN_W'(1);

    // Write strobe gated combinationally so a paused or stalled byte is never repeated.
    assign mem_wr = (state == WRITE) && rdy_in && !io_stall_c;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= IDLE;
            last_grant <= GNT_W'(NUM_PORTS - 1);
            xfer_len   <= '0;
            byte_idx   <= '0;
            wbuf       <= '0;
            mem_a      <= '0;
            mem_dout   <= '0;
            resp_done  <= '0;
            resp_rdata <= '0;
        end else if (rdy_in) begin
            case (state)
                IDLE: begin
                    if (gnt_found_c) begin
                        last_grant <= gnt_port_c;
                        mem_a      <= req_addr[gnt_port_c*ADDR_W +: ADDR_W];
                        xfer_len   <= req_len[gnt_port_c*LEN_W +: LEN_W];
                        byte_idx   <= '0;
                        resp_rdata <= '0;
                        if (req_we[gnt_port_c]) begin
                            state    <= WRITE;
                            mem_dout <= req_wdata[gnt_port_c*DATA_W +: 8];
                            wbuf     <= req_wdata[gnt_port_c*DATA_W +: DATA_W] >> 8;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                // Address for byte k goes out while byte k-1 returns on mem_din.
                READ: begin
                    if (req_abort[last_grant]) begin
                        state <= IDLE;
                    end else begin
                        if (byte_idx != '0) begin
                            resp_rdata[8*cap_idx_c +: 8] <= mem_din;
                        end
                        if (byte_idx == xfer_len) begin
                            state     <= DONE;
                            resp_done <= done_oh_c;
                        end else begin
                            byte_idx <= byte_idx + LEN_W'(1);
                            if (byte_idx + LEN_W'(1) != xfer_len) begin
                                mem_a <= mem_a + ADDR_W'(1);
                            end
                        end
                    end
                end
                WRITE: begin
                    if (!io_stall_c) begin
                        if (byte_idx == xfer_len - LEN_W'(1)) begin
                            state     <= DONE;
                            resp_done <= done_oh_c;
                        end else begin
                            byte_idx <= byte_idx + LEN_W'(1);
                            mem_a    <= mem_a + ADDR_W'(1);
                            mem_dout <= wbuf[7:0];
                            wbuf     <= wbuf >> 8;
                        end
                    end
                end
                DONE: begin
                    resp_done <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Directed bench for mem_arbiter_n with a cycle-step transaction model and byte-level RAM.
module tb_mem_arbiter_n;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int MB = 4;
    localparam int DW = 8 * MB;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              rdy_in;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_we;
    logic [N*AW-1:0]   req_addr;
    logic [N*3-1:0]    req_len;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      req_abort;
    logic [N-1:0]      resp_done;
    logic [DW-1:0]     resp_rdata;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [AW-1:0]     mem_a;
    logic              mem_wr;
    logic              io_buffer_full;

    mem_arbiter_n #(.NUM_PORTS(N), .ADDR_W(AW), .MAX_BYTES(MB)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_len(req_len), .req_wdata(req_wdata), .req_abort(req_abort),
        .resp_done(resp_done), .resp_rdata(resp_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
        .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int wcnt    = 0;
    logic chk_en = 1'b0;
    logic [7:0] wmem [4096];

    always @(posedge clk_in) cyc <= cyc + 1;

    // Read-only pattern memory; written bytes land in wmem.
    function automatic logic [7:0] rom(input logic [31:0] a);
        return 8'((32'(a[1:0]) + 1) * 17);
    endfunction

    function automatic logic [11:0] widx(input logic [31:0] a);
        return {a[17:16], a[9:0]};
    endfunction

    always @(posedge clk_in) begin
        if (rdy_in) mem_din <= rom(mem_a);
        if (mem_wr) begin
            wmem[widx(mem_a)] <= mem_dout;
            wcnt <= wcnt + 1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Transaction model: step n counts active cycles since grant (writes do not
    // advance while stalled); bytes go out on steps 1..len, completion on
    // step len+2 for reads and len+1 for writes.
    logic        m_act = 1'b0;
    int          m_port = 0, m_len = 0, m_n = 0, m_last = N - 1, m_pick;
    logic        m_we = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0;

    function automatic int pick(input logic [N-1:0] v, input int last);
        int r = -1;
        for (int i = 1; i <= N; i++)
            if (r < 0 && v[(last + i) % N]) r = (last + i) % N;
        return r;
    endfunction

    function automatic int done_step(input logic we, input int len);
        return we ? len + 1 : len + 2;
    endfunction

    function automatic logic stall_at(input logic [31:0] a, input int n, input logic full);
        logic [31:0] b = a + 32'(n - 1);
        return (b[17:16] == 2'b11) && full;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input int len);
        logic [31:0] r = '0;
        for (int i = 0; i < len; i++) r = r | (32'(rom(a + 32'(i))) << (8 * i));
        return r;
    endfunction

    always_comb m_pick = pick(req_valid, m_last);

    always @(posedge clk_in) begin
        if (rst_in) begin
            m_act  <= 1'b0;
            m_last <= N - 1;
            m_n    <= 0;
        end else if (rdy_in) begin
            if (!m_act) begin
                if (m_pick >= 0) begin
                    m_act   <= 1'b1;
                    m_port  <= m_pick;
                    m_last  <= m_pick;
                    m_we    <= req_we[m_pick];
                    m_addr  <= req_addr[m_pick*AW +: AW];
                    m_len   <= int'(req_len[m_pick*3 +: 3]);
                    m_wdata <= req_wdata[m_pick*DW +: DW];
                    m_n     <= 1;
                end
            end else if (m_n == done_step(m_we, m_len)) begin
                m_act <= 1'b0;
            end else if (!m_we && req_abort[m_port]) begin
                m_act <= 1'b0;
            end else if (!(m_we && stall_at(m_addr, m_n, io_buffer_full))) begin
                m_n <= m_n + 1;
            end
        end
    end

    logic [N-1:0] exp_done;
    logic         exp_issue, exp_wr;
    logic [31:0]  exp_addr;
    logic [7:0]   exp_dout;

    always_comb begin
        exp_done  = (m_act && m_n == done_step(m_we, m_len)) ? N'(1 << m_port) : '0;
        exp_issue = m_act && m_n >= 1 && m_n <= m_len;
        exp_addr  = m_addr + 32'(m_n - 1);
        exp_wr    = exp_issue && m_we && rdy_in && !stall_at(m_addr, m_n, io_buffer_full);
        exp_dout  = 8'(m_wdata >> (8 * (exp_issue ? m_n - 1 : 0)));
    end

    always @(negedge clk_in) begin
        if (chk_en) begin
            chk("resp_done", 64'(resp_done), 64'(exp_done));
            if (exp_done != '0 && !m_we) chk("resp_rdata", 64'(resp_rdata), 64'(model_read(m_addr, m_len)));
            if (exp_issue) chk("mem_a", 64'(mem_a), 64'(exp_addr));
            chk("mem_wr", 64'(mem_wr), 64'(exp_wr));
            if (exp_wr) chk("mem_dout", 64'(mem_dout), 64'(exp_dout));
        end
    end

    always @(negedge clk_in) begin
        for (int p = 0; p < N; p++)
            if (chk_en && req_valid[p])
                assert (req_len[p*3 +: 3] >= 3'd1 && req_len[p*3 +: 3] <= 3'(MB))
                    else $error("illegal req_len on port %0d", p);
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_req(input int p, input logic we, input logic [31:0] addr,
                           input int len, input logic [31:0] wd);
        req_valid[p]          = 1'b1;
        req_we[p]             = we;
        req_addr[p*AW +: AW]  = addr;
        req_len[p*3 +: 3]     = 3'(len);
        req_wdata[p*DW +: DW] = wd;
    endtask

    task automatic wait_done(input string nm, input int p, input int maxc, output int at);
        int i = 0;
        at = -1;
        while (at < 0 && i < maxc) begin
            tick();
            i++;
            if (resp_done[p]) at = cyc;
        end
        if (at < 0) begin
            vectors++;
            errors++;
            $display("FAIL %s: no resp_done within %0d cycles", nm, maxc);
        end
    endtask

    task automatic wait_any(input string nm, input int maxc, output int port);
        int i = 0;
        port = -1;
        while (port < 0 && i < maxc) begin
            tick();
            i++;
            for (int q = 0; q < N; q++) if (resp_done[q]) port = q;
        end
        if (port < 0) begin
            vectors++;
            errors++;
            $display("FAIL %s: no resp_done within %0d cycles", nm, maxc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, at, got, wc0;
        int rr_exp [6] = '{0, 1, 2, 0, 1, 2};
        rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0;
        req_valid = '0; req_we = '0; req_addr = '0; req_len = '0;
        req_wdata = '0; req_abort = '0;
        repeat (2) tick();
        chk("rst_mem_a", 64'(mem_a), 64'h0);
        chk("rst_mem_dout", 64'(mem_dout), 64'h0);
        chk("rst_resp_done", 64'(resp_done), 64'h0);
        chk("rst_resp_rdata", 64'(resp_rdata), 64'h0);
        rst_in = 1'b0;
        chk_en = 1'b1;
        tick();

        // Round robin with all ports continuously requesting single-byte reads.
        set_req(0, 1'b0, 32'h201, 1, 0);
        set_req(1, 1'b0, 32'h302, 1, 0);
        set_req(2, 1'b0, 32'h403, 1, 0);
        for (int k = 0; k < 6; k++) begin
            wait_any("rr_wait", 20, got);
            chk("rr_order", 64'(got), 64'(rr_exp[k]));
        end
        req_valid = '0;
        tick();

        // Four-byte read.
        set_req(0, 1'b0, 32'h100, 4, 0);
        t0 = cyc;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("rd_addr", 64'(mem_a), 64'(32'h100 + 32'(k - 1)));
        end
        wait_done("rd_done", 0, 10, at);
        chk("rd_latency", 64'(at - t0), 64'd6);
        chk("rd_data", 64'(resp_rdata), 64'h44332211);
        req_valid[0] = 1'b0;
        tick();

        // UART store stalled by a full buffer.
        wc0 = wcnt;
        io_buffer_full = 1'b1;
        set_req(1, 1'b1, 32'h30000, 1, 32'h41);
        t0 = cyc;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("st_stall_wr", 64'(mem_wr), 64'h0);
        end
        tick();
        io_buffer_full = 1'b0;
        #1;
        chk("st_wr", 64'(mem_wr), 64'h1);
        chk("st_addr", 64'(mem_a), 64'h30000);
        chk("st_dout", 64'(mem_dout), 64'h41);
        wait_done("st_done", 1, 10, at);
        chk("st_latency", 64'(at - t0), 64'd5);
        req_valid[1] = 1'b0;
        tick();
        chk("st_ram", 64'(wmem[widx(32'h30000)]), 64'h41);
        chk("st_count", 64'(wcnt - wc0), 64'd1);

        // Flush abort of port 0 with port 1 pending.
        set_req(0, 1'b0, 32'h100, 4, 0);
        set_req(1, 1'b0, 32'h201, 1, 0);
        t0 = cyc;
        tick();
        tick();
        req_abort[0] = 1'b1;
        req_valid[0] = 1'b0;
        tick();
        req_abort[0] = 1'b0;
        tick();
        chk("ab_next_addr", 64'(mem_a), 64'h201);
        wait_done("ab_done", 1, 10, at);
        chk("ab_latency", 64'(at - t0), 64'd6);
        chk("ab_data", 64'(resp_rdata), 64'h22);
        req_valid[1] = 1'b0;
        tick();

        // Pause for five cycles in the middle of a four-byte write.
        wc0 = wcnt;
        set_req(2, 1'b1, 32'h500, 4, 32'hDDCCBBAA);
        t0 = cyc;
        tick();
        tick();
        tick();
        rdy_in = 1'b0;
        #1;
        chk("ps_wr", 64'(mem_wr), 64'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("ps_addr", 64'(mem_a), 64'h502);
            chk("ps_wr", 64'(mem_wr), 64'h0);
        end
        tick();
        rdy_in = 1'b1;
        wait_done("ps_done", 2, 10, at);
        chk("ps_latency", 64'(at - t0), 64'd10);
        req_valid[2] = 1'b0;
        tick();
        chk("ps_count", 64'(wcnt - wc0), 64'd4);
        for (int k = 0; k < 4; k++)
            chk("ps_ram", 64'(wmem[widx(32'h500 + 32'(k))]), 64'(8'hAA + 8'(k * 17)));

        // Reset in the middle of a read.
        set_req(0, 1'b0, 32'h100, 4, 0);
        tick();
        tick();
        rst_in = 1'b1;
        req_valid[0] = 1'b0;
        tick();
        chk("mr_mem_a", 64'(mem_a), 64'h0);
        chk("mr_mem_dout", 64'(mem_dout), 64'h0);
        chk("mr_resp_done", 64'(resp_done), 64'h0);
        chk("mr_resp_rdata", 64'(resp_rdata), 64'h0);
        chk("mr_mem_wr", 64'(mem_wr), 64'h0);
        rst_in = 1'b0;
        set_req(0, 1'b0, 32'h100, 1, 0);
        set_req(1, 1'b0, 32'h302, 1, 0);
        wait_any("mr_first", 10, got);
        chk("mr_first_port", 64'(got), 64'd0);
        req_valid[0] = 1'b0;
        wait_any("mr_second", 10, got);
        chk("mr_second_port", 64'(got), 64'd1);
        req_valid = '0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
